// File: rtl/tdm_msb_transmitter.sv
// tdm_msb_transmitter
//   Multi-slot MSB-first serial transmitter. It streams frames out of a
//   1-bit-wide circular frame buffer and generates bclk/fsync/data for a
//   downstream receiver. At (re)sync the read pointer is placed FRAME_LAG
//   frames behind the writer's newest complete frame. If the next frame has
//   not been written yet, the transmitter mutes that frame and pulses
//   underrun_o instead of replaying stale data.
//
// Ports
//   clk_i                  system clock
//   rst_ni                 asynchronous active-low reset
//   ram_data_i             buffer read data, one cycle after ram_read_addr_o
//   resync_req_i           level request to realign with the writer
//   last_good_frame_idx_i  newest complete frame in the buffer
//   ram_read_addr_o        {frame_ptr, bit index}
//   running_o              high while streaming
//   bclk_o                 bit clock; idles low
//   fsync_o                frame sync, 50% duty
//   data_o                 serial data, changes on bclk falling edge
//   underrun_o             one-cycle pulse per muted frame
module tdm_msb_transmitter #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int SLOTS         = 8,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_HALF     = 1,
  parameter int MODE          = 0,
  parameter int FRAME_LAG     = 1,
  localparam int FRAME_BITS   = SLOTS * SLOT_BITS,
  localparam int BW           = $clog2(FRAME_BITS),
  localparam int AW           = CIRC_BUF_BITS + BW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ram_data_i,
  input  logic                     resync_req_i,
  input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
  output logic [AW-1:0]            ram_read_addr_o,
  output logic                     running_o,
  output logic                     bclk_o,
  output logic                     fsync_o,
  output logic                     data_o,
  output logic                     underrun_o
);

  localparam int CW = $clog2(2 * BCLK_HALF);
  localparam logic [CW-1:0] CNT_RISE = CW'(BCLK_HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * BCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_e;

  state_e                   state_q, state_d;
  logic [CIRC_BUF_BITS-1:0] frame_ptr_q, frame_ptr_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     mute_q, mute_d;
  logic                     bclk_q, bclk_d;
  logic                     fsync_q, fsync_d;
  logic                     data_q, data_d;
  logic                     running_q, running_d;
  logic                     underrun_q, underrun_d;

  logic                     bit_strobe;
  logic [CIRC_BUF_BITS-1:0] resync_ptr;
  logic [BW-1:0]            fs_idx;

  assign resync_ptr = last_good_frame_idx_i - CIRC_BUF_BITS'(FRAME_LAG);

  // In I2S mode fsync leads the data by one bit: the level for bit b is the
  // left-justified level of bit b+1 (wrapping at the frame end).
  assign fs_idx = (MODE == 1) ? bit_q + 1'b1 : bit_q;

  always_comb begin
    state_d     = state_q;
    frame_ptr_d = frame_ptr_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    mute_d      = mute_q;
    bclk_d      = bclk_q;
    fsync_d     = fsync_q;
    data_d      = data_q;
    running_d   = running_q;
    underrun_d  = 1'b0;
    bit_strobe  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (resync_req_i) begin
          state_d     = PRIME;
          frame_ptr_d = resync_ptr;
          bit_d       = '0;
          cnt_d       = '0;
          mute_d      = 1'b0;
        end
      end
      PRIME: begin
        // Hold address of bit 0 for one full bit period so the first load
        // sees settled RAM data, exactly like every later bit.
        if (cnt_q == CNT_LAST) begin
          state_d    = RUN;
          running_d  = 1'b1;
          cnt_d      = '0;
          bit_strobe = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_RISE) begin
          bclk_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          bclk_d     = 1'b0;
          bit_strobe = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit start (bclk falling edge): emit the bit at the current address and
    // move the address on; the wrap to bit 0 is the frame boundary.
    if (bit_strobe) begin
      data_d  = ram_data_i & ~mute_q;
      fsync_d = ~fs_idx[BW-1];
      bit_d   = bit_q + 1'b1;
      if (bit_q == BIT_LAST) begin
        if (resync_req_i) begin
          frame_ptr_d = resync_ptr;
          mute_d      = 1'b0;
        end else if (frame_ptr_q == last_good_frame_idx_i) begin
          mute_d     = 1'b1;
          underrun_d = 1'b1;
        end else begin
          frame_ptr_d = frame_ptr_q + 1'b1;
          mute_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      frame_ptr_q <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      mute_q      <= 1'b0;
      bclk_q      <= 1'b0;
      fsync_q     <= 1'b0;
      data_q      <= 1'b0;
      running_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_ptr_q <= frame_ptr_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      mute_q      <= mute_d;
      bclk_q      <= bclk_d;
      fsync_q     <= fsync_d;
      data_q      <= data_d;
      running_q   <= running_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ram_read_addr_o = {frame_ptr_q, bit_q};
  assign running_o       = running_q;
  assign bclk_o          = bclk_q;
  assign fsync_o         = fsync_q;
  assign data_o          = data_q;
  assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_tdm_msb_transmitter.sv
// Testbench for tdm_msb_transmitter: random buffer contents, scripted and
// random writer/resync behaviour, frame-level reference model feeding a
// scoreboard checked by an independent receiver process.
module tb_tdm_msb_transmitter;
  localparam int CB        = 3;
  localparam int SLOTS     = 2;
  localparam int SLOT_BITS = 16;
  localparam int BCLK_HALF = 2;
  localparam int MODE      = 1;
  localparam int LAG       = 2;
  localparam int FB        = SLOTS * SLOT_BITS;
  localparam int NFR       = 1 << CB;
  localparam int AW        = CB + $clog2(FB);
  localparam int NB        = 36;
  localparam int ND        = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_data = 1'b0;
  logic          resync = 1'b0;
  logic [CB-1:0] lg = '0;
  logic [AW-1:0] addr;
  logic          running, bclk, fsync, data, underrun;

  tdm_msb_transmitter #(
    .CIRC_BUF_BITS(CB),
    .SLOTS(SLOTS),
    .SLOT_BITS(SLOT_BITS),
    .BCLK_HALF(BCLK_HALF),
    .MODE(MODE),
    .FRAME_LAG(LAG)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .ram_data_i(ram_data),
    .resync_req_i(resync),
    .last_good_frame_idx_i(lg),
    .ram_read_addr_o(addr),
    .running_o(running),
    .bclk_o(bclk),
    .fsync_o(fsync),
    .data_o(data),
    .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  logic mem [NFR*FB];
  always @(posedge clk) ram_data <= mem[addr];

  typedef struct packed { logic d; logic fs; } bit_exp_t;
  typedef struct packed { int ptr; int und; } frm_exp_t;

  bit_exp_t bq[$];
  frm_exp_t fq[$];
  int errors = 0;
  int checks = 0;
  int rx_count = 0;
  bit mon_en = 1'b0;
  int m_ptr = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wrap_frame(input int v);
    return ((v % NFR) + NFR) % NFR;
  endfunction

  // Expected serial stream of one frame: buffer bits in order (or zeros when
  // muted) and the framing level for each bit position.
  task automatic push_frame(input int p, input bit mute, input int und);
    bit_exp_t e;
    frm_exp_t f;
    for (int b = 0; b < FB; b++) begin
      e.d  = mute ? 1'b0 : mem[p*FB + b];
      e.fs = (MODE == 0) ? (b < FB/2) : (((b + 1) % FB) < FB/2);
      bq.push_back(e);
    end
    f.ptr = p;
    f.und = und;
    fq.push_back(f);
  endtask

  // Writer/resync state applied for the next frame boundary, and the frame
  // the transmitter must choose there.
  task automatic boundary(input logic [CB-1:0] new_lg, input bit rs);
    lg = new_lg;
    resync = rs;
    if (rs) begin
      m_ptr = wrap_frame(int'(new_lg) - LAG);
      push_frame(m_ptr, 1'b0, 0);
    end else if (m_ptr == int'(new_lg)) begin
      push_frame(m_ptr, 1'b1, 1);
    end else begin
      m_ptr = wrap_frame(m_ptr + 1);
      push_frame(m_ptr, 1'b0, 0);
    end
  endtask

  task automatic wait_rx(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (rx_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_rx: received %0d bits, expected %0d", rx_count, target);
    end
  endtask

  task automatic idle_quiet(input int n, input string name);
    int act;
    act = 0;
    repeat (n) begin
      @(negedge clk);
      if (running || bclk || fsync || data || underrun || addr != '0) act++;
    end
    chk(name, act, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_bclk"}, int'(bclk), 0);
    chk({tag, "_fsync"}, int'(fsync), 0);
    chk({tag, "_data"}, int'(data), 0);
    chk({tag, "_underrun"}, int'(underrun), 0);
    chk({tag, "_addr"}, int'(addr), 0);
  endtask

  // Receiver / scoreboard: samples on each bclk rising edge.
  initial begin
    logic     bclk_prev;
    int       cyc;
    int       und_cnt;
    int       bi;
    bit       seen_rise;
    bit_exp_t e;
    frm_exp_t f;
    bclk_prev = 1'b0;
    cyc = 0;
    und_cnt = 0;
    seen_rise = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        if (underrun) und_cnt++;
        if (bclk && !bclk_prev) begin
          bi = rx_count % FB;
          if (seen_rise) chk("bclk_period", cyc, 2*BCLK_HALF);
          seen_rise = 1'b1;
          cyc = 0;
          if (bq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: bit %0d received with no expectation", rx_count);
          end else begin
            e = bq.pop_front();
            chk("data_o", int'(data), int'(e.d));
            chk("fsync_o", int'(fsync), int'(e.fs));
          end
          if (bi == FB/2) begin
            if (fq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: frame at bit %0d with no expectation", rx_count);
            end else begin
              f = fq.pop_front();
              chk("underrun_pulses", und_cnt, f.und);
              chk("addr_frame_field", int'(addr[AW-1 -: CB]), f.ptr);
            end
            und_cnt = 0;
          end
          rx_count++;
        end
      end else begin
        cyc = 0;
        und_cnt = 0;
        seen_rise = 1'b0;
      end
      bclk_prev = bclk;
    end
  end

  initial begin
    bit ok;
    for (int i = 0; i < NFR*FB; i++) mem[i] = 1'($urandom);

    // Reset state and idle without resync.
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle_quiet(30, "idle_no_resync");

    // Long run: tracking writer with pointer wrap, frozen writer, random.
    @(posedge clk);
    #1;
    rx_count = 0;
    mon_en = 1'b1;
    lg = 3'd5;
    resync = 1'b1;
    m_ptr = wrap_frame(5 - LAG);
    push_frame(m_ptr, 1'b0, 0);
    ok = 1'b1;
    for (int k = 1; k < NB && ok; k++) begin
      wait_rx((k - 1)*FB + 8, ok);
      if (ok) begin
        if (k <= 10)      boundary(lg + CB'(1), 1'b0);
        else if (k <= 15) boundary(lg, 1'b0);
        else              boundary(CB'($urandom_range(0, NFR - 1)), ($urandom_range(0, 3) == 0));
      end
    end
    if (ok) wait_rx(NB*FB, ok);
    mon_en = 1'b0;

    // Asynchronous reset mid-frame.
    if (ok) begin
      repeat (10) @(posedge clk);
      chk("running_before_reset", int'(running), 1);
      #3;
      rst_n = 1'b0;
      resync = 1'b0;
      #1;
      chk_zero("async_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_quiet(40, "idle_after_reset");

      // Restart with a pointer that wraps below zero, then 7 -> 0.
      @(posedge clk);
      #1;
      bq.delete();
      fq.delete();
      rx_count = 0;
      mon_en = 1'b1;
      lg = 3'd1;
      resync = 1'b1;
      m_ptr = wrap_frame(1 - LAG);
      push_frame(m_ptr, 1'b0, 0);
      for (int k = 1; k < ND && ok; k++) begin
        wait_rx((k - 1)*FB + 8, ok);
        if (ok) boundary(lg + CB'(1), 1'b0);
      end
      if (ok) wait_rx(ND*FB, ok);
      mon_en = 1'b0;
      chk("queue_drained", bq.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
